// File: rtl/aes_wddl_out_collect.sv
// Dual-rail (WDDL) to single-rail receiver: checks each byte for rail complementarity and
// precharge spacing, assembles NBYTES bytes into one block, and hands it off over valid/ready.
module aes_wddl_out_collect #(
  parameter int unsigned NBYTES       = 16,
  parameter bit          CHECK_SPACER = 1'b1,
  localparam int unsigned CW          = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_p,
  input  logic [7:0]            in_n,
  output logic                  in_ready,
  input  logic                  err_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic [CW-1:0]         byte_cnt,
  output logic                  err_rail,
  output logic                  err_spacer
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [8*NBYTES-1:0] data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                err_rail_q, err_rail_d;
  logic                err_spacer_q, err_spacer_d;

  logic is_cw, is_sp, beat, armed, accept, drop_sp, drop_rail;

  assign is_cw     = (in_p == ~in_n);
  assign is_sp     = (in_p == 8'h00) && (in_n == 8'h00);
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign beat      = in_valid & in_ready;
  assign armed     = CHECK_SPACER ? armed_q : 1'b1;
  assign accept    = beat & is_cw & armed;
  assign drop_sp   = beat & is_cw & ~armed;
  assign drop_rail = beat & ~is_cw;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    // A new error on the same edge as err_clr keeps the flag set.
    err_rail_d   = (err_rail_q & ~err_clr) | drop_rail;
    err_spacer_d = (err_spacer_q & ~err_clr) | drop_sp;

    if (is_sp) begin
      armed_d = 1'b1;
    end else if (beat) begin
      armed_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) begin
              data_d[8*(NBYTES-1-i) +: 8] = in_p;
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NBYTES - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COLLECT;
      data_q       <= '0;
      cnt_q        <= '0;
      armed_q      <= 1'b1;
      err_rail_q   <= 1'b0;
      err_spacer_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      err_rail_q   <= err_rail_d;
      err_spacer_q <= err_spacer_d;
    end
  end

  assign out_data   = data_q;
  assign byte_cnt   = cnt_q;
  assign err_rail   = err_rail_q;
  assign err_spacer = err_spacer_q;

endmodule

// File: tb/tb_aes_wddl_out_collect.sv
// Bench for aes_wddl_out_collect: directed beats, scoreboard of expected blocks checked by a
// monitor on each handshake, plus direct checks of flags, counters and reset behaviour.
module tb_aes_wddl_out_collect;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, err_clr, out_ready;
  logic [7:0]   in_p, in_n;
  logic         in_ready, out_valid, err_rail, err_spacer;
  logic [127:0] out_data;
  logic [4:0]   byte_cnt;

  // second instance with the spacer check disabled, own stimulus
  logic         b_valid;
  logic [7:0]   b_p, b_n;
  logic         b_in_ready, b_out_valid, b_err_rail, b_err_spacer;
  logic [127:0] b_out_data;
  logic [4:0]   b_byte_cnt;

  int checks   = 0;
  int failures = 0;
  int nblocks  = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_wddl_out_collect #(.NBYTES(16), .CHECK_SPACER(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_p(in_p), .in_n(in_n),
    .in_ready(in_ready), .err_clr(err_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .byte_cnt(byte_cnt), .err_rail(err_rail), .err_spacer(err_spacer)
  );

  aes_wddl_out_collect #(.NBYTES(16), .CHECK_SPACER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_p(b_p), .in_n(b_n),
    .in_ready(b_in_ready), .err_clr(1'b0), .out_valid(b_out_valid), .out_ready(1'b1),
    .out_data(b_out_data), .byte_cnt(b_byte_cnt), .err_rail(b_err_rail),
    .err_spacer(b_err_spacer)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every handshake must match the oldest expected block
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", out_data, 128'hx);
      end else begin
        chk("block_data", out_data, exp_q.pop_front());
        nblocks++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] n);
    in_valid = 1'b1; in_p = p; in_n = n;
    step();
    in_valid = 1'b0;
  endtask

  task automatic spacer();
    in_valid = 1'b0; in_p = 8'h00; in_n = 8'h00;
    step();
  endtask

  task automatic good(input logic [7:0] k);
    spacer();
    send(k, ~k);
  endtask

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = base + 8'(i);
    return v;
  endfunction

  logic [127:0] blk3;
  logic [15:0]  b_top;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_p = 8'h00; in_n = 8'h00;
    err_clr = 1'b0; out_ready = 1'b0;
    b_valid = 1'b0; b_p = 8'h00; b_n = 8'h00;
    repeat (3) step();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_byte_cnt", 128'(byte_cnt), 128'd0);
    chk("rst_err_rail", 128'(err_rail), 128'd0);
    chk("rst_err_spacer", 128'(err_spacer), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b1;
    step();

    // 1: clean block 00..0F
    out_ready = 1'b1;
    exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
    for (int k = 0; k < 16; k++) begin
      good(8'(k));
      if (k == 4) chk("t1_cnt5", 128'(byte_cnt), 128'd5);
    end
    chk("t1_valid", 128'(out_valid), 128'd1);
    chk("t1_cnt16", 128'(byte_cnt), 128'd16);
    chk("t1_in_ready0", 128'(in_ready), 128'd0);
    chk("t1_errs", {126'd0, err_rail, err_spacer}, 128'd0);
    step();
    chk("t1_released", 128'(out_valid), 128'd0);
    chk("t1_cnt0", 128'(byte_cnt), 128'd0);

    // 2: illegal rail pair mid-block, block still completes
    exp_q.push_back(ramp(8'h10));
    for (int k = 0; k < 16; k++) begin
      good(8'h10 + 8'(k));
      if (k == 7) begin
        spacer();
        send(8'hA5, 8'hA4);
        chk("t2_err_rail", 128'(err_rail), 128'd1);
        chk("t2_cnt_hold", 128'(byte_cnt), 128'd8);
      end
    end
    chk("t2_valid", 128'(out_valid), 128'd1);
    step();
    chk("t2_err_sticky", 128'(err_rail), 128'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t2_err_cleared", 128'(err_rail), 128'd0);

    // 3b: spacer check disabled, back-to-back codewords both accepted
    b_valid = 1'b1; b_p = 8'h55; b_n = 8'hAA; step();
    b_p = 8'h66; b_n = 8'h99; step();
    b_valid = 1'b0; b_p = 8'h00; b_n = 8'h00; step();
    chk("t3b_cnt", 128'(b_byte_cnt), 128'd2);
    chk("t3b_errs", {126'd0, b_err_rail, b_err_spacer}, 128'd0);
    b_top = b_out_data[127:112];
    chk("t3b_data", 128'(b_top), 128'h5566);

    // 3: missing spacer drops second codeword; 4: hold with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) blk3[127-8*i -: 8] = (i == 0) ? 8'h20 : 8'h21 + 8'(i);
    exp_q.push_back(blk3);
    spacer();
    send(8'h20, 8'hDF);
    send(8'h21, 8'hDE);
    chk("t3_err_spacer", 128'(err_spacer), 128'd1);
    chk("t3_cnt1", 128'(byte_cnt), 128'd1);
    chk("t3_err_rail0", 128'(err_rail), 128'd0);
    for (int i = 1; i < 16; i++) good(8'h21 + 8'(i));
    chk("t4_valid", 128'(out_valid), 128'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_p = (c % 2 == 0) ? 8'h00 : 8'h77;
      in_n = (c % 2 == 0) ? 8'h00 : 8'h88;
      step();
      chk("t4_in_ready0", 128'(in_ready), 128'd0);
      chk("t4_data_stable", out_data, blk3);
      chk("t4_cnt16", 128'(byte_cnt), 128'd16);
    end
    in_valid = 1'b0; in_p = 8'h00; in_n = 8'h00;
    chk("t4_no_rail_err", 128'(err_rail), 128'd0);
    out_ready = 1'b1;
    step();
    chk("t4_released", 128'(out_valid), 128'd0);
    chk("t4_cnt0", 128'(byte_cnt), 128'd0);
    chk("t4_in_ready1", 128'(in_ready), 128'd1);
    chk("t4_data_kept", out_data, blk3);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // 5: error wins over simultaneous clear
    chk("t5_pre", {126'd0, err_rail, err_spacer}, 128'd0);
    spacer();
    err_clr = 1'b1;
    send(8'hA5, 8'hA4);
    chk("t5_err_wins", 128'(err_rail), 128'd1);
    step();
    err_clr = 1'b0;
    chk("t5_cleared", {126'd0, err_rail, err_spacer}, 128'd0);

    // 6: reset mid-block, then a fresh block
    for (int k = 0; k < 7; k++) good(8'h40 + 8'(k));
    chk("t6_cnt7", 128'(byte_cnt), 128'd7);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_cnt", 128'(byte_cnt), 128'd0);
    chk("t6_rst_data", out_data, 128'd0);
    chk("t6_rst_valid", 128'(out_valid), 128'd0);
    step();
    rst = 1'b1;
    exp_q.push_back(ramp(8'h80));
    for (int k = 0; k < 16; k++) good(8'h80 + 8'(k));
    chk("t6_valid", 128'(out_valid), 128'd1);
    step();
    chk("t6_released", 128'(out_valid), 128'd0);

    repeat (2) step();
    chk("sb_empty", 128'(exp_q.size()), 128'd0);
    chk("sb_blocks", 128'(nblocks), 128'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
